display_scheduler: RTL and testbench
====================================

DISPLAY_SCHEDULER -- requirements
Module: display_scheduler

Interface
REQ-001 Parameter DWELL, default 50_000_000: number of clk cycles each granted source holds the display; legal range 2..2^27-1.
REQ-002 clk  input  1  system clock; all state changes on rising edge.
REQ-003 reset  input  1  synchronous, active-low reset; sampled on rising clk edge.
REQ-004 req  input  4  per-source display request, level-sensitive, bit i = source i.
REQ-005 data0, data1, data2, data3  input  32 each  value source i wants displayed.
REQ-006 freeze  input  1  level; pauses dwell counting while high.
REQ-007 grant  output  4  one-hot owner of the display; all zeros when no owner.
REQ-008 done  output  4  one-cycle pulse on bit i when source i completes a full dwell.
REQ-009 disp_value  output  32  snapshot driven to the 8-digit display's 32-bit register input.
REQ-010 disp_src  output  2  index of the source whose value is in disp_value.
REQ-011 busy  output  1  high while state is SHOW or DONE.

Function
REQ-012 FSM SHALL have exactly three states: IDLE, SHOW, DONE; all outputs registered.
REQ-013 IDLE: if req != 0, select winner, go SHOW next edge; else remain IDLE, grant = 0.
REQ-014 Arbitration SHALL be round-robin from pointer last: priority order last+1, last+2, last+3, last (mod 4).
REQ-015 On IDLE->SHOW edge: grant = onehot(winner), disp_src = winner, disp_value = data[winner], dwell counter = 0, last = winner.
REQ-016 disp_value SHALL stay constant for the whole SHOW/DONE period; data changes after capture are ignored.
REQ-017 Latency: req sampled in IDLE at edge n -> grant and disp_value valid after edge n (visible cycle n+1).
REQ-018 SHOW: counter increments by 1 per cycle when freeze = 0; holds when freeze = 1.
REQ-019 SHOW: when counter == DWELL-1 and freeze = 0, next edge -> DONE; grant SHALL be high for exactly DWELL unfrozen cycles.
REQ-020 DONE: grant = 0, done[disp_src] = 1 for exactly one cycle, then IDLE unconditionally.
REQ-021 Early release: if req[disp_src] = 0 while in SHOW, next edge -> IDLE, grant = 0, no done pulse; takes precedence over REQ-019 and over freeze.
REQ-022 The mandatory IDLE cycle after DONE or early release SHALL allow re-arbitration; one requester continuously asserting SHALL not block others.
REQ-023 Requests arriving while busy SHALL be held by the requester; nothing is queued internally.
REQ-024 In IDLE disp_value and disp_src SHALL retain last captured values (display shows last owner's data).
REQ-025 Dwell counter SHALL be 27 bits, unsigned, never wrapping within legal DWELL.
REQ-026 grant SHALL never have more than one bit set; done SHALL never have more than one bit set.

Reset
REQ-027 When reset = 0 at a rising edge: state = IDLE, grant = 0, done = 0, busy = 0, disp_value = 32'h0, disp_src = 0, counter = 0, last = 3 (source 0 wins first).
REQ-028 Reset asserted mid-SHOW or DONE SHALL abort without a done pulse; req is ignored while reset = 0.
REQ-029 First arbitration SHALL occur at the first edge with reset = 1.

Verification
REQ-030 reset low 3 cycles with req = 4'b1111, data0 = 32'h12345678 -> all outputs zero during reset; one cycle after release grant = 4'b0001, disp_value = 32'h12345678, busy = 1.
REQ-031 DWELL = 4, req = 4'b0010, data1 = 32'hDEADBEEF -> grant = 4'b0010 for 4 cycles, then done = 4'b0010 one cycle, IDLE one cycle, grant 4'b0010 again.
REQ-032 DWELL = 4, req = 4'b1111 held -> grant sequence 0001, 0010, 0100, 1000, 0001, each 4 cycles, separated by DONE+IDLE gaps; data change mid-SHOW does not alter disp_value.
REQ-033 DWELL = 4, freeze high 3 cycles mid-SHOW -> grant high 7 cycles total, single done pulse.
REQ-034 DWELL = 8, req[2] dropped after 3 SHOW cycles -> grant = 0 next cycle, done stays 0, disp_value retains data2, next requester granted after IDLE.
REQ-035 reset pulsed low during SHOW of source 3 -> grant = 0, no done, disp_value = 0, next grant goes to lowest requesting index.

Source files
------------

// File: rtl/display_scheduler.sv
// rtl/display_scheduler.sv - round-robin scheduler that gives one of four sources the 8-digit display for a fixed dwell
// Outputs are registered; the snapshot in disp_value persists through IDLE until the next capture.
module display_scheduler #(
    parameter int unsigned DWELL = 50_000_000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [3:0]  req,
    input  logic [31:0] data0,
    input  logic [31:0] data1,
    input  logic [31:0] data2,
    input  logic [31:0] data3,
    input  logic        freeze,
    output logic [3:0]  grant,
    output logic [3:0]  done,
    output logic [31:0] disp_value,
    output logic [1:0]  disp_src,
    output logic        busy
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_SHOW = 2'd1,
        S_DONE = 2'd2
    } state_t;

    localparam logic [26:0] LP_LAST_CNT = 27'(DWELL - 1);

    state_t      r_state;
    logic [26:0] r_cnt;
    logic [1:0]  r_last;
    logic [3:0]  r_grant;
    logic [3:0]  r_done;
    logic [31:0] r_value;
    logic [1:0]  r_src;
    logic        r_busy;

    state_t      w_state_nxt;
    logic [26:0] w_cnt_nxt;
    logic [1:0]  w_last_nxt;
    logic [3:0]  w_grant_nxt;
    logic [3:0]  w_done_nxt;
    logic [31:0] w_value_nxt;
    logic [1:0]  w_src_nxt;
    logic        w_busy_nxt;
    logic [1:0]  w_win;
    logic [31:0] w_win_data;

    // Scanning from farthest to nearest lets the nearest requester after last overwrite the pick.
    function automatic logic [1:0] rr_pick(input logic [3:0] r, input logic [1:0] last);
        logic [1:0] pick;
        logic [1:0] idx;
        pick = last;
        for (int k = 4; k >= 1; k--) begin
            idx = last + 2'(k);
            if (r[idx]) pick = idx;
        end
        return pick;
    endfunction

    assign w_win = rr_pick(req, r_last);

    always_comb begin
        w_win_data = data0;
        case (w_win)
            2'd0:    w_win_data = data0;
            2'd1:    w_win_data = data1;
            2'd2:    w_win_data = data2;
            default: w_win_data = data3;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_last  <= 2'd3;
            r_grant <= '0;
            r_done  <= '0;
            r_value <= '0;
            r_src   <= '0;
            r_busy  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_last  <= w_last_nxt;
            r_grant <= w_grant_nxt;
            r_done  <= w_done_nxt;
            r_value <= w_value_nxt;
            r_src   <= w_src_nxt;
            r_busy  <= w_busy_nxt;
        end
    end

    // Early release outranks both dwell completion and freeze.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: if (|req) w_state_nxt = S_SHOW;
            S_SHOW: begin
                if (!req[r_src])
                    w_state_nxt = S_IDLE;
                else if (!freeze && r_cnt == LP_LAST_CNT)
                    w_state_nxt = S_DONE;
            end
            S_DONE:  w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        w_grant_nxt = '0;
        w_done_nxt  = '0;
        w_value_nxt = r_value;
        w_src_nxt   = r_src;
        w_cnt_nxt   = r_cnt;
        w_last_nxt  = r_last;
        w_busy_nxt  = (w_state_nxt != S_IDLE);
        case (r_state)
            S_IDLE: begin
                if (|req) begin
                    w_grant_nxt = 4'b0001 << w_win;
                    w_value_nxt = w_win_data;
                    w_src_nxt   = w_win;
                    w_cnt_nxt   = '0;
                    w_last_nxt  = w_win;
                end
            end
            S_SHOW: begin
                if (w_state_nxt == S_SHOW) begin
                    w_grant_nxt = r_grant;
                    if (!freeze) w_cnt_nxt = r_cnt + 27'd1;
                end else if (w_state_nxt == S_DONE) begin
                    w_done_nxt = 4'b0001 << r_src;
                end
            end
            default: begin
            end
        endcase
    end

    assign grant      = r_grant;
    assign done       = r_done;
    assign disp_value = r_value;
    assign disp_src   = r_src;
    assign busy       = r_busy;

endmodule

// File: tb/tb_display_scheduler.sv
// tb/tb_display_scheduler.sv - directed and randomized checks of display_scheduler against a behavioural model
module tb_display_scheduler;

    localparam int LP_DWELL = 4;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [3:0]  req = '0;
    logic        freeze = 1'b0;
    logic [31:0] d [4];
    logic [3:0]  grant;
    logic [3:0]  done;
    logic [31:0] disp_value;
    logic [1:0]  disp_src;
    logic        busy;

    int n_checks = 0;
    int n_fail = 0;

    // Model: who owns the display, how many unfrozen cycles served, who is in its done cycle.
    int          m_owner = -1;
    int          m_fin = -1;
    int          m_served = 0;
    int          m_last = 3;
    int          m_src = 0;
    logic [31:0] m_value = '0;

    display_scheduler #(.DWELL(LP_DWELL)) dut (
        .clk(clk), .reset(reset), .req(req),
        .data0(d[0]), .data1(d[1]), .data2(d[2]), .data3(d[3]),
        .freeze(freeze), .grant(grant), .done(done),
        .disp_value(disp_value), .disp_src(disp_src), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s actual=%0h expected=%0h", tag, act, exp);
        end
    endtask

    task automatic model_step();
        int p_owner;
        int p_fin;
        p_owner = m_owner;
        p_fin   = m_fin;
        if (!reset) begin
            m_owner = -1; m_fin = -1; m_served = 0;
            m_last = 3; m_src = 0; m_value = '0;
        end else if (p_fin >= 0) begin
            m_fin = -1;
        end else if (p_owner >= 0) begin
            if (!req[p_owner]) begin
                m_owner = -1;
            end else if (!freeze) begin
                m_served++;
                if (m_served == LP_DWELL) begin
                    m_fin = p_owner;
                    m_owner = -1;
                end
            end
        end else if (req != 4'b0) begin
            for (int k = 1; k <= 4; k++) begin
                if (req[(m_last + k) % 4]) begin
                    m_owner = (m_last + k) % 4;
                    break;
                end
            end
            m_served = 0;
            m_src    = m_owner;
            m_value  = d[m_owner];
            m_last   = m_owner;
        end
    endtask

    task automatic compare_all();
        logic [3:0] e_grant;
        logic [3:0] e_done;
        e_grant = (m_owner >= 0) ? 4'(1 << m_owner) : 4'b0;
        e_done  = (m_fin >= 0) ? 4'(1 << m_fin) : 4'b0;
        chk("grant", 32'(grant), 32'(e_grant));
        chk("done", 32'(done), 32'(e_done));
        chk("busy", 32'(busy), 32'(m_owner >= 0 || m_fin >= 0));
        chk("disp_value", disp_value, m_value);
        chk("disp_src", 32'(disp_src), 32'(m_src));
        chk("grant_onehot", 32'($countones(grant) <= 1), 32'd1);
        chk("done_onehot", 32'($countones(done) <= 1), 32'd1);
    endtask

    task automatic cycle(input logic rs, input logic [3:0] rq, input logic fz);
        reset  = rs;
        req    = rq;
        freeze = fz;
        @(posedge clk);
        model_step();
        @(negedge clk);
        compare_all();
    endtask

    initial begin
        int gcnt;
        int dcnt;
        logic [3:0] rq;
        for (int i = 0; i < 4; i++) d[i] = '0;
        @(negedge clk);

        // Reset with all requesting, then first grant to source 0
        d[0] = 32'h12345678;
        for (int i = 0; i < 3; i++) cycle(1'b0, 4'b1111, 1'b0);
        chk("rst_grant", 32'(grant), 32'd0);
        chk("rst_value", disp_value, 32'h0);
        cycle(1'b1, 4'b1111, 1'b0);
        chk("first_grant", 32'(grant), 32'b0001);
        chk("first_value", disp_value, 32'h12345678);
        chk("first_busy", 32'(busy), 32'd1);
        for (int i = 0; i < 26; i++) begin
            d[i % 4] = $urandom;
            cycle(1'b1, 4'b1111, 1'b0);
        end

        // Single requester: dwell, done, idle, regrant
        cycle(1'b0, 4'b0000, 1'b0);
        d[1] = 32'hDEADBEEF;
        for (int i = 0; i < LP_DWELL; i++) begin
            cycle(1'b1, 4'b0010, 1'b0);
            chk("single_grant", 32'(grant), 32'b0010);
        end
        cycle(1'b1, 4'b0010, 1'b0);
        chk("single_done", 32'(done), 32'b0010);
        chk("single_done_grant", 32'(grant), 32'd0);
        cycle(1'b1, 4'b0010, 1'b0);
        chk("single_idle_busy", 32'(busy), 32'd0);
        cycle(1'b1, 4'b0010, 1'b0);
        chk("single_regrant", 32'(grant), 32'b0010);
        chk("single_value", disp_value, 32'hDEADBEEF);

        // Freeze for three cycles stretches the grant to DWELL+3
        cycle(1'b0, 4'b0000, 1'b0);
        gcnt = 0;
        dcnt = 0;
        for (int i = 0; i < 9; i++) begin
            cycle(1'b1, 4'b0001, (i >= 2 && i < 5));
            if (grant != 4'b0) gcnt++;
            if (done != 4'b0) dcnt++;
        end
        chk("freeze_grant_cycles", 32'(gcnt), 32'(LP_DWELL + 3));
        chk("freeze_done_pulses", 32'(dcnt), 32'd1);

        // Early release of source 2 after three SHOW cycles
        cycle(1'b0, 4'b0000, 1'b0);
        d[2] = 32'hCAFEF00D;
        cycle(1'b1, 4'b0100, 1'b0);
        cycle(1'b1, 4'b0100, 1'b0);
        cycle(1'b1, 4'b0100, 1'b0);
        cycle(1'b1, 4'b1001, 1'b0);
        chk("rel_grant", 32'(grant), 32'd0);
        chk("rel_done", 32'(done), 32'd0);
        chk("rel_value", disp_value, 32'hCAFEF00D);
        cycle(1'b1, 4'b1001, 1'b0);
        chk("rel_next_grant", 32'(grant), 32'b1000);

        // Reset mid-SHOW of source 3
        cycle(1'b1, 4'b1000, 1'b0);
        cycle(1'b0, 4'b1010, 1'b0);
        chk("midrst_grant", 32'(grant), 32'd0);
        chk("midrst_done", 32'(done), 32'd0);
        chk("midrst_value", disp_value, 32'd0);
        cycle(1'b1, 4'b1010, 1'b0);
        chk("midrst_next", 32'(grant), 32'b0010);

        // Randomized traffic
        rq = 4'b1111;
        for (int i = 0; i < 3000; i++) begin
            for (int j = 0; j < 4; j++) d[j] = $urandom;
            if ($urandom_range(0, 9) == 0) rq = 4'($urandom);
            cycle(($urandom_range(0, 99) != 0), rq, ($urandom_range(0, 6) == 0));
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
